// File: rtl/game_ctl.sv
// game_ctl: Duck Hunt round sequencer -- launches ducks, tracks ammo, hits, rounds and score.
// Optional GAME_CTL_SPEEDUP_EN: duck horizontal speed rises by one for each round passed.
module game_ctl #(
   parameter int SHOTS           = 3,
   parameter int DUCKS_PER_ROUND = 10,
   parameter int PASS_HITS       = 6,
   parameter int TIMEOUT_FRAMES  = 600,
   parameter int POINTS          = 100,
   parameter int BASE_H_SPD      = 10,
   parameter int REFLECTIONS     = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        new_frame,
   input  logic        shot,
   input  logic        duck_hit,
   input  logic        duck_show,
   output logic        duck_launch,
   output logic        duck_escape,
   output logic [4:0]  duck_h_spd,
   output logic [4:0]  reflections,
   output logic [1:0]  ammo,
   output logic [3:0]  hits,
   output logic [3:0]  round,
   output logic [13:0] score,
   output logic        game_over
);
   localparam logic [1:0]  L_SHOTS   = SHOTS[1:0];
   localparam logic [3:0]  L_DUCKS   = DUCKS_PER_ROUND[3:0];
   localparam logic [3:0]  L_PASS    = PASS_HITS[3:0];
   localparam logic [9:0]  L_TIMEOUT = TIMEOUT_FRAMES[9:0];
   localparam logic [13:0] L_POINTS  = POINTS[13:0];
   localparam logic [4:0]  L_BASE    = BASE_H_SPD[4:0];
   localparam logic [4:0]  L_REFL    = REFLECTIONS[4:0];

   typedef enum logic [2:0] {
      S_IDLE, S_LAUNCH, S_FLY, S_FALL, S_ESCAPE, S_NEXT, S_OVER
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [9:0]  r_frame, w_frame_nxt;
   logic [3:0]  r_ducks, w_ducks_nxt;
   logic [1:0]  r_ammo, w_ammo_nxt;
   logic [3:0]  r_hits, w_hits_nxt;
   logic [3:0]  r_round, w_round_nxt;
   logic [13:0] r_score, w_score_nxt;
   logic [4:0]  r_h_spd, w_h_spd_nxt;
   logic [4:0]  r_refl;
   logic        r_launch, r_escape, r_over;
   logic        r_hit_prev;
   logic        w_hit_rise, w_round_done, w_round_pass;

   function automatic logic [13:0] score_add(input logic [13:0] a);
      logic [14:0] s;
      s = {1'b0, a} + {1'b0, L_POINTS};
      return s[14] ? 14'h3FFF : s[13:0];
   endfunction

   function automatic logic [3:0] round_inc(input logic [3:0] r);
      return (r == 4'hF) ? 4'hF : r + 4'd1;
   endfunction

`ifdef GAME_CTL_SPEEDUP_EN
   function automatic logic [4:0] speed_for(input logic [3:0] r);
      logic [5:0] s;
      s = {1'b0, L_BASE} + {2'b00, r};
      return s[5] ? 5'd31 : s[4:0];
   endfunction
`endif

   assign w_hit_rise   = duck_hit & ~r_hit_prev;
   assign w_round_done = ((r_ducks + 4'd1) == L_DUCKS);
   assign w_round_pass = (r_hits >= L_PASS);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (shot) w_state_nxt = S_LAUNCH;
         S_LAUNCH: w_state_nxt = S_FLY;
         S_FLY: begin
            // a hit on the last shot still counts, so the hit test goes first
            if (w_hit_rise)                w_state_nxt = S_FALL;
            else if (r_frame >= L_TIMEOUT) w_state_nxt = S_ESCAPE;
            else if (r_ammo == 2'd0)       w_state_nxt = S_ESCAPE;
         end
         S_FALL, S_ESCAPE: if (!duck_show) w_state_nxt = S_NEXT;
         S_NEXT:   w_state_nxt = (w_round_done && !w_round_pass) ? S_OVER : S_LAUNCH;
         S_OVER:   if (shot) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_frame_nxt = r_frame;
      w_ducks_nxt = r_ducks;
      w_ammo_nxt  = r_ammo;
      w_hits_nxt  = r_hits;
      w_round_nxt = r_round;
      w_score_nxt = r_score;
      w_h_spd_nxt = r_h_spd;

      case (r_state)
         S_FLY: begin
            if (shot && (r_ammo != 2'd0)) w_ammo_nxt = r_ammo - 2'd1;
            if (new_frame)                w_frame_nxt = r_frame + 10'd1;
            if (w_hit_rise) begin
               w_hits_nxt  = r_hits + 4'd1;
               w_score_nxt = score_add(r_score);
            end
         end
         S_NEXT: begin
            if (w_round_done) begin
               if (w_round_pass) begin
                  w_round_nxt = round_inc(r_round);
                  w_hits_nxt  = 4'd0;
                  w_ducks_nxt = 4'd0;
`ifdef GAME_CTL_SPEEDUP_EN
                  w_h_spd_nxt = speed_for(round_inc(r_round));
`endif
               end else begin
                  w_ducks_nxt = r_ducks + 4'd1;
               end
            end else begin
               w_ducks_nxt = r_ducks + 4'd1;
            end
         end
         S_OVER: begin
            if (shot) begin
               w_score_nxt = 14'd0;
               w_round_nxt = 4'd0;
               w_hits_nxt  = 4'd0;
               w_ducks_nxt = 4'd0;
               w_h_spd_nxt = L_BASE;
            end
         end
         default: ;
      endcase

      if (w_state_nxt == S_LAUNCH) begin
         w_ammo_nxt  = L_SHOTS;
         w_frame_nxt = 10'd0;
      end
   end

   // outputs are registered images of the next state and next counter values
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_frame    <= 10'd0;
         r_ducks    <= 4'd0;
         r_ammo     <= 2'd0;
         r_hits     <= 4'd0;
         r_round    <= 4'd0;
         r_score    <= 14'd0;
         r_h_spd    <= L_BASE;
         r_refl     <= L_REFL;
         r_launch   <= 1'b0;
         r_escape   <= 1'b0;
         r_over     <= 1'b0;
         r_hit_prev <= 1'b0;
      end else begin
         r_frame    <= w_frame_nxt;
         r_ducks    <= w_ducks_nxt;
         r_ammo     <= w_ammo_nxt;
         r_hits     <= w_hits_nxt;
         r_round    <= w_round_nxt;
         r_score    <= w_score_nxt;
         r_h_spd    <= w_h_spd_nxt;
         r_refl     <= L_REFL;
         r_launch   <= (w_state_nxt == S_LAUNCH);
         r_escape   <= (w_state_nxt == S_ESCAPE);
         r_over     <= (w_state_nxt == S_OVER);
         r_hit_prev <= duck_hit;
      end
   end

   assign duck_launch = r_launch;
   assign duck_escape = r_escape;
   assign duck_h_spd  = r_h_spd;
   assign reflections = r_refl;
   assign ammo        = r_ammo;
   assign hits        = r_hits;
   assign round       = r_round;
   assign score       = r_score;
   assign game_over   = r_over;

endmodule

// File: tb/tb_game_ctl.sv
// Bench for game_ctl: directed scenarios plus randomized rounds against a score/round model.
`timescale 1ns/1ps
module tb_game_ctl;
   logic        clk = 1'b0;
   logic        rst, new_frame, shot, duck_hit, duck_show;
   logic        duck_launch, duck_escape, game_over;
   logic [4:0]  duck_h_spd, reflections;
   logic [1:0]  ammo;
   logic [3:0]  hits, round;
   logic [13:0] score;

   int n_pass  = 0;
   int n_total = 0;
   int m_hits, m_round, m_score, m_ducks;

   always #5 clk = ~clk;

   game_ctl dut (
      .clk(clk), .rst(rst), .new_frame(new_frame), .shot(shot),
      .duck_hit(duck_hit), .duck_show(duck_show),
      .duck_launch(duck_launch), .duck_escape(duck_escape),
      .duck_h_spd(duck_h_spd), .reflections(reflections),
      .ammo(ammo), .hits(hits), .round(round), .score(score),
      .game_over(game_over)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int exp_spd(int r);
`ifdef GAME_CTL_SPEEDUP_EN
      return (10 + r > 31) ? 31 : 10 + r;
`else
      if (r < 0) return 0;
      return 10;
`endif
   endfunction

   task automatic reset_dut();
      rst = 1'b1; new_frame = 1'b0; shot = 1'b0; duck_hit = 1'b0; duck_show = 1'b0;
      tick(); tick();
      rst = 1'b0;
      m_hits = 0; m_round = 0; m_score = 0; m_ducks = 0;
   endtask

   task automatic start_game();
      shot = 1'b1; tick(); shot = 1'b0;
      n_total++; if (duck_launch !== 1'b1) $display("FAIL start_launch: got %b want 1", duck_launch); else n_pass++;
      n_total++; if (ammo !== 2'd3) $display("FAIL start_ammo: got %0d want 3", ammo); else n_pass++;
      duck_show = 1'b1;
      tick();
      n_total++; if (duck_launch !== 1'b0) $display("FAIL launch_pulse_width: got %b want 0", duck_launch); else n_pass++;
   endtask

   // Plays one duck from the first FLY cycle to the next launch (or game over).
   task automatic play_duck(input bit hit, input int pre_shots, input int max_gap, output bit over);
      int exp_ammo;
      int nshots;
      exp_ammo = 3;
      nshots = hit ? pre_shots : 3;
      over = 1'b0;
      for (int i = 0; i < nshots; i++) begin
         repeat ($urandom_range(max_gap, 0)) tick();
         shot = 1'b1; tick(); shot = 1'b0;
         exp_ammo--;
         n_total++; if (ammo !== 2'(exp_ammo)) $display("FAIL duck_ammo: got %0d want %0d", ammo, exp_ammo); else n_pass++;
      end
      if (hit) begin
         repeat ($urandom_range(max_gap, 0)) tick();
         shot = 1'b1; duck_hit = 1'b1; tick(); shot = 1'b0; duck_hit = 1'b0;
         exp_ammo--;
         m_hits++;
         m_score = (m_score + 100 > 16383) ? 16383 : m_score + 100;
         n_total++; if (hits !== 4'(m_hits)) $display("FAIL hit_count: got %0d want %0d", hits, m_hits); else n_pass++;
         n_total++; if (score !== 14'(m_score)) $display("FAIL hit_score: got %0d want %0d", score, m_score); else n_pass++;
         n_total++; if (ammo !== 2'(exp_ammo)) $display("FAIL hit_ammo: got %0d want %0d", ammo, exp_ammo); else n_pass++;
         n_total++; if (duck_escape !== 1'b0) $display("FAIL hit_no_escape: got %b want 0", duck_escape); else n_pass++;
      end else begin
         tick();
         n_total++; if (duck_escape !== 1'b1) $display("FAIL miss_escape: got %b want 1", duck_escape); else n_pass++;
      end
      duck_show = 1'b0;
      tick();
      tick();
      m_ducks++;
      if (m_ducks == 10) begin
         m_ducks = 0;
         if (m_hits >= 6) begin
            m_round = (m_round + 1 > 15) ? 15 : m_round + 1;
            m_hits  = 0;
         end else begin
            over = 1'b1;
         end
      end
      if (over) begin
         n_total++; if (game_over !== 1'b1) $display("FAIL over_flag: got %b want 1", game_over); else n_pass++;
      end else begin
         n_total++; if (duck_launch !== 1'b1) $display("FAIL relaunch: got %b want 1", duck_launch); else n_pass++;
      end
      n_total++; if (round !== 4'(m_round)) $display("FAIL round: got %0d want %0d", round, m_round); else n_pass++;
      n_total++; if (hits !== 4'(m_hits)) $display("FAIL round_hits: got %0d want %0d", hits, m_hits); else n_pass++;
      n_total++; if (duck_h_spd !== 5'(exp_spd(m_round))) $display("FAIL h_spd: got %0d want %0d", duck_h_spd, exp_spd(m_round)); else n_pass++;
      if (!over) begin
         duck_show = 1'b1;
         tick();
      end
   endtask

   task automatic play_round(input int k, input int max_gap, output bit over);
      bit mask [10];
      int placed;
      placed = 0;
      over = 1'b0;
      foreach (mask[i]) mask[i] = 1'b0;
      while (placed < k) begin
         int j;
         j = $urandom_range(9, 0);
         if (!mask[j]) begin mask[j] = 1'b1; placed++; end
      end
      for (int d = 0; d < 10 && !over; d++)
         play_duck(mask[d], $urandom_range(2, 0), max_gap, over);
   endtask

   task automatic test_reset();
      rst = 1'b1; new_frame = 1'b0; shot = 1'b0; duck_hit = 1'b0; duck_show = 1'b0;
      tick(); tick();
      n_total++; if (duck_launch !== 1'b0) $display("FAIL rst_launch: got %b want 0", duck_launch); else n_pass++;
      n_total++; if (duck_escape !== 1'b0) $display("FAIL rst_escape: got %b want 0", duck_escape); else n_pass++;
      n_total++; if (duck_h_spd !== 5'd10) $display("FAIL rst_h_spd: got %0d want 10", duck_h_spd); else n_pass++;
      n_total++; if (reflections !== 5'd15) $display("FAIL rst_refl: got %0d want 15", reflections); else n_pass++;
      n_total++; if (ammo !== 2'd0) $display("FAIL rst_ammo: got %0d want 0", ammo); else n_pass++;
      n_total++; if (hits !== 4'd0) $display("FAIL rst_hits: got %0d want 0", hits); else n_pass++;
      n_total++; if (round !== 4'd0) $display("FAIL rst_round: got %0d want 0", round); else n_pass++;
      n_total++; if (score !== 14'd0) $display("FAIL rst_score: got %0d want 0", score); else n_pass++;
      n_total++; if (game_over !== 1'b0) $display("FAIL rst_over: got %b want 0", game_over); else n_pass++;
      rst = 1'b0;
      tick(); tick();
      n_total++; if (duck_launch !== 1'b0) $display("FAIL idle_no_launch: got %b want 0", duck_launch); else n_pass++;
      start_game();
   endtask

   task automatic test_ammo_out();
      reset_dut();
      start_game();
      for (int i = 0; i < 3; i++) begin
         shot = 1'b1; tick(); shot = 1'b0;
         n_total++; if (ammo !== 2'(2 - i)) $display("FAIL ammo_step: got %0d want %0d", ammo, 2 - i); else n_pass++;
         n_total++; if (duck_escape !== 1'b0) $display("FAIL early_escape: got %b want 0", duck_escape); else n_pass++;
      end
      shot = 1'b1; tick(); shot = 1'b0;
      n_total++; if (ammo !== 2'd0) $display("FAIL fourth_shot: got %0d want 0", ammo); else n_pass++;
      n_total++; if (duck_escape !== 1'b1) $display("FAIL ammo_escape: got %b want 1", duck_escape); else n_pass++;
      duck_show = 1'b0; tick();
      n_total++; if (duck_escape !== 1'b0) $display("FAIL escape_drop: got %b want 0", duck_escape); else n_pass++;
      tick();
      n_total++; if (duck_launch !== 1'b1) $display("FAIL next_launch: got %b want 1", duck_launch); else n_pass++;
   endtask

   task automatic test_hit_with_shot();
      reset_dut();
      start_game();
      shot = 1'b1; duck_hit = 1'b1; tick(); shot = 1'b0;
      n_total++; if (ammo !== 2'd2) $display("FAIL hs_ammo: got %0d want 2", ammo); else n_pass++;
      n_total++; if (hits !== 4'd1) $display("FAIL hs_hits: got %0d want 1", hits); else n_pass++;
      n_total++; if (score !== 14'd100) $display("FAIL hs_score: got %0d want 100", score); else n_pass++;
      tick();
      n_total++; if (duck_launch !== 1'b0) $display("FAIL fall_wait: got %b want 0", duck_launch); else n_pass++;
      n_total++; if (hits !== 4'd1) $display("FAIL fall_hits_hold: got %0d want 1", hits); else n_pass++;
      duck_show = 1'b0; duck_hit = 1'b0; tick();
      n_total++; if (duck_launch !== 1'b0) $display("FAIL fall_next: got %b want 0", duck_launch); else n_pass++;
      tick();
      n_total++; if (duck_launch !== 1'b1) $display("FAIL fall_relaunch: got %b want 1", duck_launch); else n_pass++;
   endtask

   task automatic test_timeout();
      reset_dut();
      start_game();
      for (int i = 0; i < 599; i++) begin
         new_frame = 1'b1; tick(); new_frame = 1'b0; tick();
      end
      n_total++; if (duck_escape !== 1'b0) $display("FAIL timeout_early: got %b want 0", duck_escape); else n_pass++;
      new_frame = 1'b1; tick(); new_frame = 1'b0; tick();
      n_total++; if (duck_escape !== 1'b1) $display("FAIL timeout_escape: got %b want 1", duck_escape); else n_pass++;
      n_total++; if (ammo !== 2'd3) $display("FAIL timeout_ammo: got %0d want 3", ammo); else n_pass++;
   endtask

   task automatic test_rounds();
      bit over;
      reset_dut();
      start_game();
      play_round(6, 3, over);
      n_total++; if (over !== 1'b0) $display("FAIL pass_round_over: got %b want 0", over); else n_pass++;
      play_round(5, 3, over);
      n_total++; if (game_over !== 1'b1) $display("FAIL fail_round_over: got %b want 1", game_over); else n_pass++;
      repeat (3) tick();
      n_total++; if (score !== 14'(m_score)) $display("FAIL over_frozen: got %0d want %0d", score, m_score); else n_pass++;
      shot = 1'b1; tick(); shot = 1'b0;
      n_total++; if (game_over !== 1'b0) $display("FAIL idle_over: got %b want 0", game_over); else n_pass++;
      n_total++; if (score !== 14'd0) $display("FAIL idle_score: got %0d want 0", score); else n_pass++;
      n_total++; if (round !== 4'd0) $display("FAIL idle_round: got %0d want 0", round); else n_pass++;
      n_total++; if (duck_h_spd !== 5'd10) $display("FAIL idle_h_spd: got %0d want 10", duck_h_spd); else n_pass++;
      shot = 1'b1; tick(); shot = 1'b0;
      n_total++; if (duck_launch !== 1'b1) $display("FAIL restart_launch: got %b want 1", duck_launch); else n_pass++;
   endtask

   task automatic test_random_rounds();
      bit over;
      reset_dut();
      start_game();
      over = 1'b0;
      for (int r = 0; r < 6 && !over; r++)
         play_round($urandom_range(10, 4), 4, over);
   endtask

   task automatic test_saturation();
      bit over;
      reset_dut();
      start_game();
      over = 1'b0;
      for (int r = 0; r < 17 && !over; r++)
         play_round(10, 0, over);
      n_total++; if (score !== 14'd16383) $display("FAIL score_sat: got %0d want 16383", score); else n_pass++;
      n_total++; if (round !== 4'd15) $display("FAIL round_sat: got %0d want 15", round); else n_pass++;
   endtask

   task automatic test_reset_mid_flight();
      reset_dut();
      start_game();
      shot = 1'b1; tick(); shot = 1'b0;
      shot = 1'b1; tick(); shot = 1'b0;
      n_total++; if (ammo !== 2'd1) $display("FAIL pre_rst_ammo: got %0d want 1", ammo); else n_pass++;
      rst = 1'b1;
      #1;
      n_total++; if (ammo !== 2'd0) $display("FAIL async_rst_ammo: got %0d want 0", ammo); else n_pass++;
      n_total++; if (duck_launch !== 1'b0) $display("FAIL async_rst_launch: got %b want 0", duck_launch); else n_pass++;
      n_total++; if (duck_h_spd !== 5'd10) $display("FAIL async_rst_h_spd: got %0d want 10", duck_h_spd); else n_pass++;
      n_total++; if (reflections !== 5'd15) $display("FAIL async_rst_refl: got %0d want 15", reflections); else n_pass++;
      tick();
      rst = 1'b0;
      duck_show = 1'b0;
      tick();
      shot = 1'b1; tick(); shot = 1'b0;
      n_total++; if (duck_launch !== 1'b1) $display("FAIL post_rst_idle: got %b want 1", duck_launch); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_ammo_out();
      test_hit_with_shot();
      test_timeout();
      test_rounds();
      test_random_rounds();
      test_saturation();
      test_reset_mid_flight();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
